// File: rtl/operand_sequencer_pkg.sv
// Shared constants and types for the operand sequencer: register selects,
// datapath width, FSM state encoding and the latched instruction record.
package operand_sequencer_pkg;
  localparam int WORD_SIZE = 19;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_A    = 2'b01;
  localparam logic [1:0] SEL_B    = 2'b10;
  localparam logic [1:0] SEL_C    = 2'b11;

  typedef enum logic [2:0] {
    IDLE, RD1, RD2, CAP, EXEC, WAIT, WB, ERR
  } seq_state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] src1;
    logic [1:0] src2;
    logic [1:0] dst;
  } instr_t;
endpackage

// File: rtl/operand_sequencer_timeout.sv
// Saturating 8-bit cycle counter bounding how long the sequencer waits on the ALU.
module seq_timeout_counter #(
  parameter int LIMIT = 16
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [7:0] r_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                         r_cnt <= '0;
    else if (clear)                     r_cnt <= '0;
    else if (enable && r_cnt != 8'hFF)  r_cnt <= r_cnt + 8'd1;
  end

  // Fires during the LIMIT-th enabled cycle so the FSM leaves on that edge.
  assign expired = enable && (r_cnt >= 8'(LIMIT - 1));
endmodule

// File: rtl/operand_sequencer.sv
// Reads two operands from the register file, issues one ALU request, waits
// (bounded) for the result and writes it back to the destination register.
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int ALU_TIMEOUT = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [3:0]           instr_op,
  input  logic [1:0]           instr_src1,
  input  logic [1:0]           instr_src2,
  input  logic [1:0]           instr_dst,
  output logic                 LOAD_REG,
  output logic [1:0]           LOAD_SELECT,
  output logic [WORD_SIZE-1:0] rf_data_in,
  input  logic [WORD_SIZE-1:0] rf_data_out,
  output logic                 alu_req_valid,
  input  logic                 alu_req_ready,
  output logic [3:0]           alu_op,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  input  logic                 alu_rsp_valid,
  input  logic [WORD_SIZE-1:0] alu_result,
  output logic                 done,
  output logic                 error
);
  seq_state_t           r_state, w_next;
  instr_t               r_instr;
  logic [WORD_SIZE-1:0] r_opa, r_opb, r_res;
  logic                 r_live;
  logic                 w_accept, w_sel_bad, w_expired;

  // r_live keeps instr_ready low while in reset and until the first clock after it.
  assign instr_ready = r_live && (r_state == IDLE);
  assign w_accept    = instr_ready && instr_valid;
  assign w_sel_bad   = (instr_src1 == SEL_NONE) || (instr_src2 == SEL_NONE) ||
                       (instr_dst == SEL_NONE);

  seq_timeout_counter #(.LIMIT(ALU_TIMEOUT)) u_tmo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .clear   (r_state == CAP),
    .enable  ((r_state == EXEC) || (r_state == WAIT)),
    .expired (w_expired)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_instr <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
      if (w_accept) r_instr <= '{op: instr_op, src1: instr_src1, src2: instr_src2, dst: instr_dst};
      if (r_state == RD2) r_opa <= rf_data_out;
      if (r_state == CAP) r_opb <= rf_data_out;
      if (r_state == WAIT && alu_rsp_valid) r_res <= alu_result;
    end
  end

  always_comb begin
    w_next        = r_state;
    LOAD_REG      = 1'b0;
    LOAD_SELECT   = SEL_NONE;
    alu_req_valid = 1'b0;
    done          = 1'b0;
    error         = 1'b0;
    case (r_state)
      IDLE: if (w_accept) w_next = w_sel_bad ? ERR : RD1;
      RD1: begin
        LOAD_SELECT = r_instr.src1;
        w_next      = RD2;
      end
      RD2: begin
        LOAD_SELECT = r_instr.src2;
        w_next      = CAP;
      end
      CAP: w_next = EXEC;
      EXEC: begin
        alu_req_valid = 1'b1;
        if (w_expired)          w_next = ERR;
        else if (alu_req_ready) w_next = WAIT;
      end
      WAIT: begin
        if (w_expired)          w_next = ERR;
        else if (alu_rsp_valid) w_next = WB;
      end
      WB: begin
        LOAD_REG    = 1'b1;
        LOAD_SELECT = r_instr.dst;
        done        = 1'b1;
        w_next      = IDLE;
      end
      ERR: begin
        error  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Buses are only meaningful while their strobe is up; keep them quiet otherwise.
  assign alu_op     = alu_req_valid ? r_instr.op : 4'd0;
  assign alu_a      = alu_req_valid ? r_opa : '0;
  assign alu_b      = alu_req_valid ? r_opb : '0;
  assign rf_data_in = LOAD_REG ? r_res : '0;
endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench: a registered-read register file and a scripted ALU are
// modelled in tasks; each scenario checks its own hand-computed results.
module tb_operand_sequencer;
  import operand_sequencer_pkg::*;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_PASS = 4'h1;

  logic        CLK, RST_N, instr_valid, instr_ready;
  logic [3:0]  instr_op;
  logic [1:0]  instr_src1, instr_src2, instr_dst;
  logic        LOAD_REG;
  logic [1:0]  LOAD_SELECT;
  logic [18:0] rf_data_in, rf_data_out;
  logic        alu_req_valid, alu_req_ready;
  logic [3:0]  alu_op;
  logic [18:0] alu_a, alu_b;
  logic        alu_rsp_valid;
  logic [18:0] alu_result;
  logic        done, error;

  operand_sequencer #(.ALU_TIMEOUT(16)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_src1(instr_src1), .instr_src2(instr_src2), .instr_dst(instr_dst),
    .LOAD_REG(LOAD_REG), .LOAD_SELECT(LOAD_SELECT),
    .rf_data_in(rf_data_in), .rf_data_out(rf_data_out),
    .alu_req_valid(alu_req_valid), .alu_req_ready(alu_req_ready), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_rsp_valid(alu_rsp_valid), .alu_result(alu_result),
    .done(done), .error(error)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int          n_vec = 0, n_err = 0;
  logic [18:0] regs [4];
  logic [18:0] pending;
  int          done_lat, err_lat;
  bit          saw_load, saw_read, ab_stable, rdy_offer;
  logic [18:0] a_seen, b_seen, wdata;
  logic [3:0]  op_seen;
  logic [1:0]  wsel;

  // Register file with one cycle of read latency, stepped once per negedge.
  task automatic rf_step();
    rf_data_out = pending;
    pending     = (LOAD_SELECT != SEL_NONE) ? regs[LOAD_SELECT] : 19'd0;
    if (LOAD_REG && LOAD_SELECT != SEL_NONE) regs[LOAD_SELECT] = rf_data_in;
  endtask

  // Offer one instruction, then play the ALU: ready after `stall` request
  // cycles, response one cycle after the request handshake if `respond`.
  task automatic run_instr(input logic [3:0] op, input logic [1:0] s1, s2, d,
                           input int stall, input bit respond, input int abort_at);
    int req_n = 0, hs = -1, w = 0;
    done_lat = -1; err_lat = -1; saw_load = 0; saw_read = 0; ab_stable = 1;
    a_seen = '0; b_seen = '0; op_seen = '0; wsel = '0; wdata = '0;
    @(negedge CLK); rf_step();
    rdy_offer = instr_ready;
    while (!instr_ready && w < 20) begin @(negedge CLK); rf_step(); w++; end
    instr_valid = 1'b1; instr_op = op; instr_src1 = s1; instr_src2 = s2; instr_dst = d;
    @(negedge CLK);
    instr_valid = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) @(negedge CLK);
      rf_step();
      alu_req_ready = 1'b0; alu_rsp_valid = 1'b0;
      if (LOAD_REG) begin saw_load = 1; wsel = LOAD_SELECT; wdata = rf_data_in; end
      else if (LOAD_SELECT != SEL_NONE) saw_read = 1;
      if (alu_req_valid) begin
        if (req_n == 0) begin a_seen = alu_a; b_seen = alu_b; op_seen = alu_op; end
        else if (alu_a !== a_seen || alu_b !== b_seen || alu_op !== op_seen) ab_stable = 0;
        if (req_n >= stall) begin alu_req_ready = 1'b1; hs = k; end
        req_n++;
      end
      if (respond && hs >= 0 && k == hs + 1) begin
        alu_rsp_valid = 1'b1;
        alu_result    = (op_seen == OP_ADD) ? a_seen + b_seen : a_seen;
      end
      if (done)  done_lat = k;
      if (error) err_lat  = k;
      if (done || error || k == abort_at) break;
    end
  endtask

  task automatic test_reset();
    #1;
    n_vec++; if ({instr_ready, LOAD_REG, LOAD_SELECT, alu_req_valid, done, error} !== 7'd0 ||
                 {rf_data_in, alu_a, alu_b, alu_op} !== 61'd0) begin
      n_err++; $display("FAIL reset_outputs: ctl=%b data_nonzero=%b want all zero",
        {instr_ready, LOAD_REG, LOAD_SELECT, alu_req_valid, done, error},
        |{rf_data_in, alu_a, alu_b, alu_op});
    end
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    #1;
    n_vec++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL ready_before_clk: got %b want 0", instr_ready); end
    @(negedge CLK);
    n_vec++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_clk: got %b want 1", instr_ready); end
  endtask

  task automatic test_basic();
    regs[SEL_A] = 19'h00005; regs[SEL_B] = 19'h00003; regs[SEL_C] = 19'h0;
    run_instr(OP_ADD, SEL_A, SEL_B, SEL_C, 0, 1, 0);
    n_vec++; if (rdy_offer !== 1'b1) begin n_err++; $display("FAIL basic_ready: got %b want 1", rdy_offer); end
    n_vec++; if (done_lat != 6) begin n_err++; $display("FAIL basic_latency: got %0d want 6", done_lat); end
    n_vec++; if (err_lat != -1) begin n_err++; $display("FAIL basic_no_error: got %0d want -1", err_lat); end
    n_vec++; if (a_seen !== 19'h5 || b_seen !== 19'h3) begin n_err++; $display("FAIL basic_operands: got %h/%h want 00005/00003", a_seen, b_seen); end
    n_vec++; if (op_seen !== OP_ADD) begin n_err++; $display("FAIL basic_op: got %h want %h", op_seen, OP_ADD); end
    n_vec++; if (wsel !== SEL_C || wdata !== 19'h8) begin n_err++; $display("FAIL basic_writeback: got sel %b data %h want 11/00008", wsel, wdata); end
    n_vec++; if (regs[SEL_C] !== 19'h00008) begin n_err++; $display("FAIL basic_regC: got %h want 00008", regs[SEL_C]); end
  endtask

  task automatic test_stall();
    regs[SEL_A] = 19'h12345; regs[SEL_B] = 19'h00111;
    run_instr(OP_ADD, SEL_A, SEL_B, SEL_C, 3, 1, 0);
    n_vec++; if (done_lat != 9) begin n_err++; $display("FAIL stall_latency: got %0d want 9", done_lat); end
    n_vec++; if (!ab_stable || a_seen !== 19'h12345 || b_seen !== 19'h00111) begin
      n_err++; $display("FAIL stall_operands: stable=%0b a=%h b=%h want 1/12345/00111", ab_stable, a_seen, b_seen); end
    n_vec++; if (regs[SEL_C] !== 19'h12456) begin n_err++; $display("FAIL stall_regC: got %h want 12456", regs[SEL_C]); end
  endtask

  task automatic test_timeout();
    run_instr(OP_ADD, SEL_A, SEL_B, SEL_C, 0, 0, 0);
    n_vec++; if (err_lat != 20 || done_lat != -1) begin n_err++; $display("FAIL timeout_error: err at %0d done at %0d want 20/-1", err_lat, done_lat); end
    n_vec++; if (saw_load) begin n_err++; $display("FAIL timeout_no_write: got LOAD_REG=1 want none"); end
    n_vec++; if (regs[SEL_C] !== 19'h12456) begin n_err++; $display("FAIL timeout_regC: got %h want 12456", regs[SEL_C]); end
    @(negedge CLK); rf_step();
    n_vec++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL timeout_idle: got ready %b want 1", instr_ready); end
  endtask

  task automatic test_illegal_sel();
    run_instr(OP_ADD, SEL_A, SEL_NONE, SEL_C, 0, 1, 0);
    n_vec++; if (err_lat != 1) begin n_err++; $display("FAIL illegal_error: got %0d want 1", err_lat); end
    n_vec++; if (saw_read || saw_load) begin n_err++; $display("FAIL illegal_no_access: read=%0b load=%0b want 0/0", saw_read, saw_load); end
  endtask

  task automatic test_reset_midop();
    regs[SEL_A] = 19'h00005; regs[SEL_B] = 19'h00003; regs[SEL_C] = 19'h0;
    run_instr(OP_ADD, SEL_A, SEL_B, SEL_C, 0, 0, 5);
    alu_req_ready = 1'b0; alu_rsp_valid = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    n_vec++; if ({instr_ready, LOAD_REG, LOAD_SELECT, alu_req_valid, done, error} !== 7'd0 ||
                 {rf_data_in, alu_a, alu_b, alu_op} !== 61'd0) begin
      n_err++; $display("FAIL midop_reset_outputs: ctl=%b want 0000000", {instr_ready, LOAD_REG, LOAD_SELECT, alu_req_valid, done, error}); end
    @(negedge CLK);
    RST_N = 1'b1;
    pending = '0;
    run_instr(OP_ADD, SEL_A, SEL_B, SEL_C, 0, 1, 0);
    n_vec++; if (rdy_offer !== 1'b1 || done_lat != 6) begin n_err++; $display("FAIL midop_next: ready %b latency %0d want 1/6", rdy_offer, done_lat); end
    n_vec++; if (regs[SEL_C] !== 19'h00008) begin n_err++; $display("FAIL midop_regC: got %h want 00008", regs[SEL_C]); end
  endtask

  task automatic test_back_to_back();
    regs[SEL_A] = 19'h7FFFF; regs[SEL_B] = 19'h0;
    run_instr(OP_PASS, SEL_A, SEL_A, SEL_A, 0, 1, 0);
    n_vec++; if (done_lat != 6 || wsel !== SEL_A) begin n_err++; $display("FAIL alias_done: latency %0d sel %b want 6/01", done_lat, wsel); end
    n_vec++; if (regs[SEL_A] !== 19'h7FFFF) begin n_err++; $display("FAIL alias_regA: got %h want 7ffff", regs[SEL_A]); end
    run_instr(OP_ADD, SEL_A, SEL_A, SEL_B, 0, 1, 0);
    n_vec++; if (rdy_offer !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b want 1", rdy_offer); end
    n_vec++; if (done_lat != 6) begin n_err++; $display("FAIL b2b_latency: got %0d want 6", done_lat); end
    n_vec++; if (regs[SEL_B] !== 19'h7FFFE) begin n_err++; $display("FAIL b2b_regB: got %h want 7fffe", regs[SEL_B]); end
  endtask

  initial begin
    RST_N = 1'b0; instr_valid = 1'b0; instr_op = '0;
    instr_src1 = '0; instr_src2 = '0; instr_dst = '0;
    rf_data_out = '0; alu_req_ready = 1'b0; alu_rsp_valid = 1'b0; alu_result = '0;
    pending = '0;
    for (int i = 0; i < 4; i++) regs[i] = '0;
    test_reset();
    test_basic();
    test_stall();
    test_timeout();
    test_illegal_sel();
    test_reset_midop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t want finished", $time);
    $fatal(1);
  end
endmodule
